// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants,
// and the parity helper that the receiver and the future transmitter use.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_T0  = 7;
  localparam int SAMPLE_T1  = 8;
  localparam int SAMPLE_T2  = 9;

  // Expected parity bit for a data word. Narrower words are zero-extended.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, held in
// reset while restart is high so the first tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and flag the wrap.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling, 3-sample majority vote at ticks 7/8/9,
// optional parity, framing/overrun/break reporting, valid/ready output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  logic rx_s1_q, rx_s_q, rx_prev_q;

  uart_rx_state_e state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [3:0] bit_q, bit_d;
  logic       s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic par_q, par_d, armed_q, armed_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic ovr_q, ovr_d, brk_q, brk_d;

  logic tick, vote, at_t9, at_end, complete, par_bad, is_break;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  assign vote   = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign at_t9  = tick && (samp_q == 4'(SAMPLE_T2));
  assign at_end = tick && (samp_q == 4'(OVERSAMPLE - 1));
  assign par_bad  = (PARITY_EN != 0) &&
                    (par_q != calc_parity(8'(sh_q), 1'(PARITY_ODD)));
  // vote here is the stop-bit vote; only used when complete is high.
  assign is_break = (sh_q == '0) && ((PARITY_EN == 0) || !par_q) && !vote;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s_q    <= rx_s1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM, sample capture and output word handshake.
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    sh_d     = sh_q;
    par_d    = par_q;
    armed_d  = armed_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovr_d    = 1'b0;
    brk_d    = 1'b0;
    complete = 1'b0;

    if (tick) begin
      samp_d = samp_q + 4'd1;
      if (samp_q == 4'(SAMPLE_T0)) s7_d = rx_s_q;
      if (samp_q == 4'(SAMPLE_T1)) s8_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        // After a low stop bit, wait for the line to go high before re-arming.
        if (!armed_q && rx_s_q) armed_d = 1'b1;
        if (armed_q && rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (at_t9 && vote) state_d = IDLE;
        else if (at_end)   state_d = DATA;
      end
      DATA: begin
        if (at_t9) begin
          sh_d  = {vote, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 4'd1;
        end
        if (at_end && bit_q == 4'(DATA_BITS)) begin
          bit_d   = '0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_t9) par_d = vote;
        if (at_end) state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is caught early.
        if (at_t9) begin
          complete = 1'b1;
          state_d  = IDLE;
          if (!vote) armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (!valid_q || rx_ready) begin
        data_d  = sh_q;
        perr_d  = par_bad;
        ferr_d  = !vote;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      brk_d = is_break;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign break_det  = brk_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance (a_*) and an 8E1 instance (b_*),
// directed scenarios followed by randomized frames against a line-level model.
module tb_uart_rx_core;

  localparam int DIV     = 4;
  localparam int BIT_CLK = DIV * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rx_ready = 1'b1;

  logic [7:0] a_data, b_data;
  logic a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy;
  logic b_valid, b_perr, b_ferr, b_ovr, b_brk, b_busy;

  uart_rx_core #(.DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset(rst_n), .rx(rx_a), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(rx_ready), .parity_err(a_perr), .frame_err(a_ferr),
    .overrun(a_ovr), .break_det(a_brk), .busy(a_busy)
  );

  uart_rx_core #(.DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .rx(rx_b), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(rx_ready), .parity_err(b_perr), .frame_err(b_ferr),
    .overrun(b_ovr), .break_det(b_brk), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Observation side: accepted words {perr, ferr, data}, pulse counts, valid rise time.
  logic [9:0] got_a[$], got_b[$];
  int a_ovr_cnt = 0, a_brk_cnt = 0, a_vcyc = 0, a_busy_cnt = 0, a_rise = -1;
  int b_ovr_cnt = 0, b_brk_cnt = 0, b_rise = -1;
  logic a_vprev = 1'b0, b_vprev = 1'b0;

  always @(negedge clk) begin
    if (a_valid && rx_ready) got_a.push_back({a_perr, a_ferr, a_data});
    if (b_valid && rx_ready) got_b.push_back({b_perr, b_ferr, b_data});
    if (a_valid && !a_vprev) a_rise = cyc;
    if (b_valid && !b_vprev) b_rise = cyc;
    a_vprev = a_valid;
    b_vprev = b_valid;
    a_ovr_cnt  += int'(a_ovr);
    a_brk_cnt  += int'(a_brk);
    b_ovr_cnt  += int'(b_ovr);
    b_brk_cnt  += int'(b_brk);
    a_vcyc     += int'(a_valid);
    a_busy_cnt += int'(a_busy);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word the consumer should see for a frame as put on the line.
  // Even parity: data plus parity bit must carry an even number of ones.
  function automatic logic [9:0] model(input bit par_en, input logic [7:0] d,
                                       input logic par, input logic stop);
    logic perr;
    perr = par_en ? ($countones({d, par}) % 2 == 1) : 1'b0;
    return {perr, ~stop, d};
  endfunction

  // Cycle of the valid-loading edge: 2 sync flops + 1 edge register put START
  // 3 clk after the line falls; tick m of the frame follows DIV*(m+1) clk later,
  // and the stop bit's tick 9 is m = 16*stop_idx + 9.
  function automatic int exp_rise(input int k, input int stop_idx);
    return k + 3 + DIV * (16 * stop_idx + 10);
  endfunction

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic wait_bit();
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  // Drive one frame; the line is left at the stop value afterwards.
  task automatic send(input bit which, input logic [7:0] d, input logic par,
                      input logic stop, output int k);
    @(posedge clk); #1;
    k = cyc;
    set_rx(which, 1'b0); wait_bit();
    for (int i = 0; i < 8; i++) begin set_rx(which, d[i]); wait_bit(); end
    if (which) begin set_rx(which, par); wait_bit(); end
    set_rx(which, stop); wait_bit();
  endtask

  task automatic pop_chk(input bit which, input string tag, input logic [9:0] exp);
    logic [9:0] w;
    if (which ? (got_b.size() == 0) : (got_a.size() == 0)) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      w = which ? got_b.pop_front() : got_a.pop_front();
      chk(tag, {22'd0, w}, {22'd0, exp});
    end
  endtask

  initial begin
    int k, v0, b0, o0;
    logic [7:0] d;
    logic par, stop;
    bit which;
    int exp_brk_a, exp_brk_b;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("reset_a_outs", {a_data, a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy}, 0);
    chk("reset_b_outs", {b_data, b_valid, b_perr, b_ferr, b_ovr, b_brk, b_busy}, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 0xA5: exact latency and one-clk valid with ready high
    #1; a_rise = -1; v0 = a_vcyc;
    send(1'b0, 8'hA5, 1'b0, 1'b1, k);
    repeat (8) @(posedge clk); #1;
    chk("a5_latency", a_rise, exp_rise(k, 9));
    chk("a5_valid_width", a_vcyc - v0, 1);
    pop_chk(1'b0, "a5_word", model(1'b0, 8'hA5, 1'b0, 1'b1));
    chk("a5_no_pulses", a_ovr_cnt + a_brk_cnt, 0);

    // Short glitch: START entered, abandoned at the tick-9 vote
    v0 = a_vcyc;
    @(posedge clk); #1; rx_a = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("glitch_busy_hi", a_busy, 1);
    @(posedge clk); #1; rx_a = 1'b1;
    repeat (60) @(posedge clk); #1;
    chk("glitch_busy_lo", a_busy, 0);
    chk("glitch_no_valid", a_vcyc - v0, 0);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    b_rise = -1;
    send(1'b1, 8'h37, 1'b0, 1'b1, k);
    repeat (8) @(posedge clk); #1;
    chk("par_latency", b_rise, exp_rise(k, 10));
    pop_chk(1'b1, "par_bad", {2'b10, 8'h37});
    send(1'b1, 8'h37, 1'b1, 1'b1, k);
    repeat (8) @(posedge clk); #1;
    pop_chk(1'b1, "par_good", {2'b00, 8'h37});

    // Framing error, then a break held low well past the frame
    send(1'b0, 8'h3C, 1'b0, 1'b0, k);
    rx_a = 1'b1; repeat (10) @(posedge clk); #1;
    pop_chk(1'b0, "frame_err", {2'b01, 8'h3C});
    chk("frame_no_break", a_brk_cnt, 0);
    send(1'b0, 8'h00, 1'b0, 1'b0, k);
    a_busy_cnt = 0;
    repeat (200) @(posedge clk); #1;
    chk("break_no_retrigger", a_busy_cnt, 0);
    rx_a = 1'b1; repeat (20) @(posedge clk); #1;
    chk("break_pulse", a_brk_cnt, 1);
    pop_chk(1'b0, "break_word", {2'b01, 8'h00});
    chk("break_empty", got_a.size(), 0);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    o0 = a_ovr_cnt;
    send(1'b0, 8'h11, 1'b0, 1'b1, k);
    send(1'b0, 8'h22, 1'b0, 1'b1, k);
    repeat (10) @(posedge clk); #1;
    chk("ovr_pulse", a_ovr_cnt - o0, 1);
    chk("ovr_held", {a_valid, a_perr, a_ferr, a_data}, {3'b100, 8'h11});
    rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_valid_clear", a_valid, 0);
    pop_chk(1'b0, "ovr_word", {2'b00, 8'h11});
    chk("ovr_dropped", got_a.size(), 0);

    // Reset mid 4th data bit of 0xFF, then a clean 0x5A
    v0 = a_vcyc; o0 = a_ovr_cnt; b0 = a_brk_cnt;
    @(posedge clk); #1; rx_a = 1'b0; wait_bit();
    rx_a = 1'b1;
    repeat (3 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
    #1; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid_reset_outs", {a_valid, a_busy, a_ovr, a_brk}, 0);
    rst_n = 1'b1;
    repeat (BIT_CLK * 12) @(posedge clk); #1;
    chk("abort_no_output", (a_vcyc - v0) + (a_ovr_cnt - o0) + (a_brk_cnt - b0), 0);
    send(1'b0, 8'h5A, 1'b0, 1'b1, k);
    repeat (8) @(posedge clk); #1;
    pop_chk(1'b0, "after_reset", {2'b00, 8'h5A});

    // Randomized frames on both instances
    exp_brk_a = a_brk_cnt;
    exp_brk_b = b_brk_cnt;
    for (int n = 0; n < 16; n++) begin
      which = n[0];
      d     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      par   = 1'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      send(which, d, par, stop, k);
      set_rx(which, 1'b1);
      repeat ($urandom_range(4, 40)) @(posedge clk);
      #1;
      pop_chk(which, which ? "rand_b" : "rand_a", model(which, d, par, stop));
      if (d == 8'h00 && (!which || !par) && !stop) begin
        if (which) exp_brk_b++;
        else       exp_brk_a++;
      end
    end
    chk("rand_break_a", a_brk_cnt, exp_brk_a);
    chk("rand_break_b", b_brk_cnt, exp_brk_b);
    chk("rand_no_ovr", a_ovr_cnt + b_ovr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Synthesisable UART receiver. Consumes the serial `rx` line carried by the UART interface and delivers parallel bytes over a valid/ready handshake.
- Sits directly downstream of the line the master driver toggles; it is the DUT-side consumer the slave monitor observes.
- Uses 16x oversampling with a 3-sample majority vote, optional parity, and reports framing, parity, overrun and break conditions.

Parameters:
- DIV, 4: clk cycles per oversample tick. Must be >= 1. One bit time is DIV*16 clk cycles.
- DATA_BITS, 8: data bits per frame, range 5..8, sent LSB first.
- PARITY_EN, 0: 1 means one parity bit follows the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line. Idles high.
- rx_data  output  DATA_BITS  received data, LSB = first bit on the line.
- rx_valid  output  1  rx_data and error flags are valid.
- rx_ready  input  1  consumer accepts the current word.
- parity_err  output  1  parity mismatch on the held word. Qualified by rx_valid.
- frame_err  output  1  stop bit sampled low on the held word. Qualified by rx_valid.
- overrun  output  1  one-clk pulse: a frame completed while the previous word was unaccepted.
- break_det  output  1  one-clk pulse: all-zero frame with stop bit low.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, synchroniser flops set to 1.
- Input path: rx passes through a 2-flop synchroniser (rx_s). This adds 2 clk of latency, which is accounted for in all timing below.
- Tick generator: counts 0..DIV-1. It asserts `tick` at DIV-1 and wraps. It is held at 0 in IDLE and restarts on start-edge detection.
- Each bit spans 16 ticks, numbered 0..15 by the sample counter.
- Majority vote: rx_s is sampled at ticks 7, 8 and 9; the bit value is the majority of the three samples.
- FSM states and transitions:
  - IDLE: a falling edge on rx_s moves to START and clears the counters.
  - START: the voted value at tick 9 is checked. If 1 (false start/glitch), return to IDLE. If 0, go to DATA at tick 15.
  - DATA: the voted bit shifts into the shift register MSB-first-in, giving LSB-first on the line. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: capture the voted bit, then go to STOP.
  - STOP: at tick 9, vote the stop bit and complete the frame (see below), then go to IDLE.
- IDLE is entered at tick 9 of the stop bit, not tick 15. This gives half-bit resync tolerance, and a new start edge may be detected immediately.
- Parity computation: for even parity, parity_err = XOR(data bits, parity bit). For odd parity, parity_err is the inverse of that XOR.
- Frame completion, when rx_valid=0 or (rx_valid & rx_ready):
  - On the next clk edge, rx_data, parity_err and frame_err are loaded and rx_valid is set.
  - Latency is exactly 1 clk after the stop-bit tick-9 vote.
- Frame completion, when rx_valid=1 & rx_ready=0:
  - The held word and its flags are unchanged.
  - The new frame is dropped and overrun pulses for 1 clk.
- Handshake:
  - rx_valid stays high until sampled with rx_ready=1 on a clk edge, then clears.
  - If a new word completes on that same edge, rx_valid stays 1 and the new word is loaded.
  - rx_data and the flags are stable while rx_valid=1 & rx_ready=0.
- Break: if data==0, parity sample==0 (when enabled) and stop==0, break_det pulses.
- After a stop bit sampled low, the FSM waits in IDLE for rx_s=1 before it arms edge detection again. This prevents retriggering during a break.
- Reset mid-frame: asynchronous return to the reset state. The partial frame is discarded and no valid, overrun or break is produced.
- Simultaneous events: overrun and break_det may pulse in the same cycle. frame_err accompanies a break word when that word is accepted.

Decomposition:
- Package uart_pkg holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;`
  - localparam OVERSAMPLE = 16;
  - localparams SAMPLE_T0/T1/T2 = 7/8/9.
  - function `calc_parity(data, odd)`, shared with the future TX.
- Sub-module uart_baud_tick: parameter DIV, inputs clk, reset and restart, output tick. It is reused by the transmitter.

Test Plan:
- DIV=4, 8N1, drive frame 0xA5 at 64 clk/bit, rx_ready=1 -> rx_valid for 1 clk with rx_data=0xA5, all error flags 0, rx_valid rising 1 clk after stop tick 9.
- Drive rx low for 6 clk (< half bit) then high -> FSM returns to IDLE from START, no rx_valid, busy pulses only during the glitch.
- PARITY_EN=1, even parity, send 0x37 with parity bit 0 (correct is 1) -> rx_data=0x37, parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- Send 0x3C with stop bit driven low -> frame_err=1, rx_data=0x3C. Send 0x00 with stop low -> break_det pulse, no new start detected until rx returns high.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses at completion of the second frame. Raise rx_ready -> rx_valid clears next clk.
- Assert reset during the 4th data bit of 0xFF, release, then send 0x5A -> no output for the aborted frame, rx_data=0x5A with clean flags.
